// File: rtl/ex_mem_stage.sv
// ============================================================================
// Module   : ex_mem_stage
// Brief    : EX/MEM pipeline register with N/Z/V flag register, branch
//            resolution, fetch redirect and wrong-path squash.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_mem_stage #(
  parameter int         SQUASH_CYCLES = 2,
  parameter logic [3:0] BRANCH_OP     = 4'hC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic [15:0] ex_instr,
  input  logic [15:0] ex_alu_result,
  input  logic [15:0] ex_store_data,
  input  logic [2:0]  ex_flags,
  input  logic        ex_flag_en,
  input  logic [15:0] ex_target,
  input  logic        ex_mem_rd,
  input  logic        ex_mem_wr,
  input  logic        ex_reg_wr,
  input  logic [3:0]  ex_wr_reg,
  input  logic        mem_stall,
  output logic        ex_ready,
  output logic        mem_valid,
  output logic [15:0] mem_alu_result,
  output logic [15:0] mem_store_data,
  output logic        mem_mem_rd,
  output logic        mem_mem_wr,
  output logic        mem_reg_wr,
  output logic [3:0]  mem_wr_reg,
  output logic [2:0]  flags_q,
  output logic        redirect,
  output logic [15:0] redirect_pc
);

  localparam logic [2:0] c_CC_NE  = 3'd0;
  localparam logic [2:0] c_CC_EQ  = 3'd1;
  localparam logic [2:0] c_CC_GT  = 3'd2;
  localparam logic [2:0] c_CC_LT  = 3'd3;
  localparam logic [2:0] c_CC_GTE = 3'd4;
  localparam logic [2:0] c_CC_LTE = 3'd5;
  localparam logic [2:0] c_CC_OVF = 3'd6;
  localparam logic [1:0] c_SQUASH_LOAD = 2'(SQUASH_CYCLES);

  logic [1:0] r_squashCnt;
  logic       w_accept;
  logic       w_ev;
  logic       w_condMet;
  logic       w_taken;
  logic       w_n;
  logic       w_z;
  logic       w_v;

  assign ex_ready = ~mem_stall;
  assign w_accept = ~mem_stall;
  assign w_ev     = ex_valid & (r_squashCnt == 2'd0);
  assign {w_n, w_z, w_v} = flags_q;

  always_comb begin
    w_condMet = 1'b0;
    case (ex_instr[11:9])
      c_CC_NE:  w_condMet = ~w_z;
      c_CC_EQ:  w_condMet = w_z;
      c_CC_GT:  w_condMet = ~w_z & ~w_n;
      c_CC_LT:  w_condMet = w_n;
      c_CC_GTE: w_condMet = w_z | ~w_n;
      c_CC_LTE: w_condMet = w_n | w_z;
      c_CC_OVF: w_condMet = w_v;
      default:  w_condMet = 1'b1;
    endcase
  end

  assign w_taken = w_ev & (ex_instr[15:12] == BRANCH_OP) & w_condMet;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_squashCnt    <= 2'd0;
      mem_valid      <= 1'b0;
      mem_alu_result <= 16'h0000;
      mem_store_data <= 16'h0000;
      mem_mem_rd     <= 1'b0;
      mem_mem_wr     <= 1'b0;
      mem_reg_wr     <= 1'b0;
      mem_wr_reg     <= 4'h0;
      flags_q        <= 3'b000;
      redirect       <= 1'b0;
      redirect_pc    <= 16'h0000;
    end else begin
      redirect <= 1'b0;
      if (w_accept) begin
        mem_valid      <= w_ev;
        mem_alu_result <= ex_alu_result;
        mem_store_data <= ex_store_data;
        mem_wr_reg     <= ex_wr_reg;
        // A taken branch is kept valid in MEM but must not write anything
        mem_mem_rd     <= ex_mem_rd & w_ev & ~w_taken;
        mem_mem_wr     <= ex_mem_wr & w_ev & ~w_taken;
        mem_reg_wr     <= ex_reg_wr & w_ev & ~w_taken;
        if (w_ev && ex_flag_en) begin
          flags_q <= ex_flags;
        end
        if (w_taken) begin
          redirect    <= 1'b1;
          redirect_pc <= ex_target;
          r_squashCnt <= c_SQUASH_LOAD;
        end else if (r_squashCnt != 2'd0) begin
          r_squashCnt <= r_squashCnt - 2'd1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ex_mem_stage.sv
// Scoreboarded bench for ex_mem_stage: a driver predicts each cycle's result
// from an abstract model, and a monitor compares after every clock edge.
`default_nettype none

module tb_ex_mem_stage;

  localparam int         SQ = 2;
  localparam logic [3:0] BR = 4'hC;
  localparam logic [3:0] ADD = 4'h0;

  logic        clk = 1'b0;
  logic        rst_n, ex_valid, ex_flag_en, ex_mem_rd, ex_mem_wr, ex_reg_wr, mem_stall;
  logic [15:0] ex_instr, ex_alu_result, ex_store_data, ex_target;
  logic [2:0]  ex_flags;
  logic [3:0]  ex_wr_reg;
  logic        ex_ready, mem_valid, mem_mem_rd, mem_mem_wr, mem_reg_wr, redirect;
  logic [15:0] mem_alu_result, mem_store_data, redirect_pc;
  logic [3:0]  mem_wr_reg;
  logic [2:0]  flags_q;

  always #5 clk = ~clk;

  ex_mem_stage #(.SQUASH_CYCLES(SQ), .BRANCH_OP(BR)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_instr(ex_instr),
    .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .ex_flags(ex_flags), .ex_flag_en(ex_flag_en), .ex_target(ex_target),
    .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr), .ex_reg_wr(ex_reg_wr),
    .ex_wr_reg(ex_wr_reg), .mem_stall(mem_stall), .ex_ready(ex_ready),
    .mem_valid(mem_valid), .mem_alu_result(mem_alu_result),
    .mem_store_data(mem_store_data), .mem_mem_rd(mem_mem_rd),
    .mem_mem_wr(mem_mem_wr), .mem_reg_wr(mem_reg_wr), .mem_wr_reg(mem_wr_reg),
    .flags_q(flags_q), .redirect(redirect), .redirect_pc(redirect_pc)
  );

  typedef struct {
    logic        valid;
    logic [15:0] alu;
    logic [15:0] store;
    logic        rd;
    logic        wr;
    logic        regWr;
    logic [3:0]  wrReg;
    logic [2:0]  flags;
    logic        redirect;
    logic [15:0] redirectPc;
    logic        ready;
  } exp_t;

  exp_t model;
  exp_t sbQ[$];
  int   squashLeft = 0;
  int   vectors = 0;
  int   fails = 0;

  // Branch conditions stated directly from the named predicates
  function automatic bit condHolds(input logic [2:0] cc, input logic [2:0] f);
    bit n, z, v;
    n = f[2]; z = f[1]; v = f[0];
    case (cc)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return z || !n;
      3'd5: return n || z;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction

  task automatic predict();
    bit ev, taken;
    if (!rst_n) begin
      model = '{default: '0};
      squashLeft = 0;
    end else if (mem_stall) begin
      model.redirect = 1'b0;
    end else begin
      ev    = ex_valid && (squashLeft == 0);
      taken = ev && (ex_instr[15:12] == BR) && condHolds(ex_instr[11:9], model.flags);
      model.valid    = ev;
      model.alu      = ex_alu_result;
      model.store    = ex_store_data;
      model.wrReg    = ex_wr_reg;
      model.rd       = ex_mem_rd && ev && !taken;
      model.wr       = ex_mem_wr && ev && !taken;
      model.regWr    = ex_reg_wr && ev && !taken;
      model.redirect = taken;
      if (taken) model.redirectPc = ex_target;
      if (ev && ex_flag_en) model.flags = ex_flags;
      if (taken) squashLeft = SQ;
      else if (squashLeft > 0) squashLeft--;
    end
    model.ready = !mem_stall;
  endtask

  // One clock: apply inputs, record the prediction, advance to the next negedge
  task automatic cyc(input bit rn, input bit st, input bit v, input logic [3:0] op,
                     input logic [2:0] cc, input bit fe, input logic [2:0] fl,
                     input logic [15:0] tgt, input bit wr);
    rst_n         = rn;
    mem_stall     = st;
    ex_valid      = v;
    ex_instr      = {op, cc, 9'($urandom)};
    ex_flag_en    = fe;
    ex_flags      = fl;
    ex_target     = tgt;
    ex_reg_wr     = wr;
    ex_mem_rd     = 1'($urandom);
    ex_mem_wr     = 1'($urandom);
    ex_alu_result = 16'($urandom);
    ex_store_data = 16'($urandom);
    ex_wr_reg     = 4'($urandom);
    predict();
    sbQ.push_back(model);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    vectors++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sbQ.size() > 0) begin
      e = sbQ.pop_front();
      chk("mem_valid", 16'(mem_valid), 16'(e.valid));
      chk("redirect", 16'(redirect), 16'(e.redirect));
      chk("flags_q", 16'(flags_q), 16'(e.flags));
      chk("ex_ready", 16'(ex_ready), 16'(e.ready));
      chk("mem_reg_wr", 16'(mem_reg_wr), 16'(e.regWr));
      chk("mem_mem_rd", 16'(mem_mem_rd), 16'(e.rd));
      chk("mem_mem_wr", 16'(mem_mem_wr), 16'(e.wr));
      chk("mem_alu_result", mem_alu_result, e.alu);
      chk("mem_store_data", mem_store_data, e.store);
      chk("mem_wr_reg", 16'(mem_wr_reg), 16'(e.wrReg));
      if (e.redirect) chk("redirect_pc", redirect_pc, e.redirectPc);
    end
  end

  initial begin
    model = '{default: '0};
    // Reset held two cycles with live inputs
    cyc(0, 0, 1, ADD, 3'd0, 1, 3'b111, 16'h1234, 1);
    cyc(0, 0, 1, ADD, 3'd0, 1, 3'b111, 16'h1234, 1);
    // Flag set then taken EQ, two squashed slots, then normal
    cyc(1, 0, 1, ADD, 3'd0, 1, 3'b010, 16'h0000, 1);
    cyc(1, 0, 1, BR,  3'd1, 0, 3'b000, 16'h0040, 0);
    cyc(1, 0, 1, ADD, 3'd0, 1, 3'b101, 16'h0000, 1);
    cyc(1, 0, 1, ADD, 3'd0, 1, 3'b101, 16'h0000, 1);
    cyc(1, 0, 1, ADD, 3'd0, 1, 3'b000, 16'h0000, 1);
    // Not-taken EQ with flags 000
    cyc(1, 0, 1, BR,  3'd1, 0, 3'b000, 16'h0080, 0);
    cyc(1, 0, 1, ADD, 3'd0, 0, 3'b000, 16'h0000, 1);
    // Stall three cycles on a flag-setting ADD, then release
    repeat (3) cyc(1, 1, 1, ADD, 3'd0, 1, 3'b100, 16'h0000, 1);
    cyc(1, 0, 1, ADD, 3'd0, 1, 3'b100, 16'h0000, 1);
    // Taken always-branch, stall two, then three accepts
    cyc(1, 0, 1, BR,  3'd7, 0, 3'b000, 16'h0100, 0);
    repeat (2) cyc(1, 1, 1, ADD, 3'd0, 0, 3'b000, 16'h0000, 1);
    repeat (3) cyc(1, 0, 1, ADD, 3'd0, 0, 3'b000, 16'h0000, 1);
    // Reset in the middle of a squash
    cyc(1, 0, 1, BR,  3'd7, 0, 3'b000, 16'h0200, 0);
    cyc(0, 0, 1, ADD, 3'd0, 0, 3'b000, 16'h0000, 1);
    cyc(1, 0, 1, ADD, 3'd0, 0, 3'b000, 16'h0000, 1);
    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 59) != 0), ($urandom_range(0, 4) == 0),
          ($urandom_range(0, 9) != 0),
          ($urandom_range(0, 3) == 0) ? BR : 4'($urandom_range(0, 11)),
          3'($urandom), 1'($urandom), 3'($urandom), 16'($urandom), 1'($urandom));
    end
    for (int k = 0; k < 5 && sbQ.size() > 0; k++) @(posedge clk);
    #2;
    if (sbQ.size() > 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expected 0", sbQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

`default_nettype wire
